ram_prog: RTL and testbench

Parametrised single-port program/data RAM for the 8-bit CPU, generalised in width and depth, with a built-in boot sequencer. After reset it clears every location, then serves the CPU over the shared tristate bus. On request it accepts a program image over a valid/ready stream, so ROM-style hard-coded contents are no longer needed. It sits on the CPU data bus beside the accumulator/ALU and is addressed by the memory address register.

---
 rtl/ram_prog_pkg.sv | 14 +
 rtl/ram_prog_if.sv | 31 +++
 rtl/ram_prog_core.sv | 28 ++
 rtl/ram_prog.sv | 125 ++++++++++++
 tb/tb_ram_prog.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_prog_pkg.sv
// Shared definitions for the boot-clearing, stream-loadable program RAM.
// Default sizes match the 8-bit CPU top.
package ram_prog_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

endpackage

// File: rtl/ram_prog_if.sv
// CPU strobes/address and program-loader stream for ram_prog.
// The shared data bus itself is a plain inout on the RAM.
interface ram_prog_if
    import ram_prog_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              ram_in;
    logic              ram_out;
    logic [ADDR_W-1:0] ram_add;
    logic              ram_rdy;
    logic              prog_start;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic [ADDR_W:0]   prog_cnt;

    modport master (
        output ram_in, ram_out, ram_add, prog_start, prog_valid, prog_data, prog_last,
        input  ram_rdy, prog_ready, prog_cnt
    );

    modport slave (
        input  ram_in, ram_out, ram_add, prog_start, prog_valid, prog_data, prog_last,
        output ram_rdy, prog_ready, prog_cnt
    );

endinterface

// File: rtl/ram_prog_core.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are not reset; the top's CLEAR sequence initialises them.
module ram_prog_core
    import ram_prog_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_prog.sv
// Program/data RAM with boot clear sequencer and valid/ready program loader.
// CPU access only in RUN; the shared bus is driven only on a pure CPU read.
module ram_prog
    import ram_prog_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    ram_prog_if.slave         io,
    inout  wire  [DATA_W-1:0] ram_bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              rdy;
    logic              ready;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              bus_oe;
    logic              take;

    assign take = (state == LOAD) && io.prog_valid;

    always_comb begin
        we    = 1'b0;
        waddr = ptr;
        wdata = '0;
        case (state)
            CLEAR: begin
                we = 1'b1;
            end
            RUN: begin
                we    = io.ram_in;
                waddr = io.ram_add;
                wdata = ram_bus;
            end
            LOAD: begin
                we    = io.prog_valid;
                wdata = io.prog_data;
            end
            default: ;
        endcase
    end

    ram_prog_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (io.ram_add),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            cnt   <= '0;
            rdy   <= 1'b0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST_ADDR) begin
                        state <= RUN;
                        rdy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (io.prog_start) begin
                        state <= LOAD;
                        ptr   <= '0;
                        cnt   <= '0;
                        rdy   <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (take) begin
                        ptr <= ptr + 1'b1;
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        // A full-depth image ends the load even without prog_last.
                        if (io.prog_last || ptr == LAST_ADDR) begin
                            state <= RUN;
                            rdy   <= 1'b1;
                            ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    rdy   <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // A simultaneous write keeps the bus released so the CPU's driver never fights ours.
    assign bus_oe  = !rst && (state == RUN) && io.ram_out && !io.ram_in;
    assign ram_bus = bus_oe ? rdata : {DATA_W{1'bz}};

    assign io.ram_rdy    = rdy;
    assign io.prog_ready = ready;
    assign io.prog_cnt   = cnt;

endmodule

// File: tb/tb_ram_prog.sv
// Randomised self-checking bench for ram_prog against an array model of memory contents.
// A weak pull-up on the bus makes a released bus read as all-ones.
module tb_ram_prog;
    import ram_prog_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] FLOAT = 8'hFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tb_drv = 1'b0;
    logic [DW-1:0] tb_wdata = '0;
    wire  [DW-1:0] ram_bus;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] ref_mem [DEPTH];

    ram_prog_if #(.DATA_W(DW), .ADDR_W(AW)) io ();

    ram_prog #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .io      (io),
        .ram_bus (ram_bus)
    );

    assign ram_bus = tb_drv ? tb_wdata : {DW{1'bz}};
    assign (weak0, weak1) ram_bus = {DW{1'b1}};

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        io.ram_in     = 1'b0;
        io.ram_out    = 1'b0;
        io.ram_add    = '0;
        io.prog_start = 1'b0;
        io.prog_valid = 1'b0;
        io.prog_data  = '0;
        io.prog_last  = 1'b0;
        tb_drv        = 1'b0;
        tb_wdata      = '0;
    endtask

    task automatic read_word(input int a, output logic [DW-1:0] d);
        cycle();
        io.ram_in  = 1'b0;
        tb_drv     = 1'b0;
        io.ram_add = AW'(a);
        io.ram_out = 1'b1;
        #2;
        d = ram_bus;
        io.ram_out = 1'b0;
    endtask

    task automatic cpu_write(input int a, input logic [DW-1:0] v);
        cycle();
        io.ram_add = AW'(a);
        io.ram_in  = 1'b1;
        tb_drv     = 1'b1;
        tb_wdata   = v;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        logic [DW-1:0] d;
        rst = 1'b1;
        idle();
        repeat (3) cycle();
        n_vec++;
        if (io.ram_rdy !== 1'b0 || io.prog_ready !== 1'b0 || io.prog_cnt !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: rdy=%b ready=%b cnt=%0d, required 0/0/0",
                     io.ram_rdy, io.prog_ready, io.prog_cnt);
        end
        #1;
        d = ram_bus;
        n_vec++;
        if (d !== FLOAT) begin
            n_err++;
            $display("FAIL reset_bus_z: bus=%h, required released (%h)", d, FLOAT);
        end
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k < DEPTH) begin
                io.ram_in     = 1'b1;
                tb_drv        = 1'b1;
                tb_wdata      = DW'($urandom_range(1, 254));
                io.ram_add    = AW'($urandom_range(0, DEPTH - 1));
                io.prog_start = 1'b1;
                io.prog_valid = 1'b1;
                io.prog_data  = DW'($urandom_range(1, 254));
            end else begin
                idle();
            end
            cycle();
            n_vec++;
            if (io.ram_rdy !== (k == DEPTH)) begin
                n_err++;
                $display("FAIL clear_rdy_timing: edge %0d rdy=%b, required %b",
                         k, io.ram_rdy, (k == DEPTH));
            end
        end
        n_vec++;
        if (io.prog_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ignores_start: prog_ready=%b, required 0", io.prog_ready);
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        for (int a = 0; a < DEPTH; a++) begin
            read_word(a, d);
            n_vec++;
            if (d !== ref_mem[a]) begin
                n_err++;
                $display("FAIL clear_sweep: addr %0d read %h, required %h", a, d, ref_mem[a]);
            end
            #1;
            n_vec++;
            if (ram_bus !== FLOAT) begin
                n_err++;
                $display("FAIL idle_bus_z: addr %0d bus=%h, required %h", a, ram_bus, FLOAT);
            end
        end
    endtask

    task automatic test_cpu_rw();
        logic [DW-1:0] d;
        int a;
        logic [DW-1:0] v;
        cpu_write(3, 8'hA5);
        ref_mem[3] = 8'hA5;
        read_word(3, d);
        n_vec++;
        if (d !== 8'hA5) begin
            n_err++;
            $display("FAIL cpu_rw_addr3: read %h, required a5", d);
        end
        cpu_write(15, 8'h3C);
        ref_mem[15] = 8'h3C;
        read_word(15, d);
        n_vec++;
        if (d !== 8'h3C) begin
            n_err++;
            $display("FAIL cpu_rw_addr15: read %h, required 3c", d);
        end
        read_word(4, d);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++;
            $display("FAIL cpu_rw_addr4: read %h, required 00", d);
        end
        // write and read strobes together: only the CPU drives the bus
        cycle();
        io.ram_add = AW'(7);
        io.ram_in  = 1'b1;
        io.ram_out = 1'b1;
        tb_drv     = 1'b1;
        tb_wdata   = 8'h5A;
        #2;
        n_vec++;
        if (ram_bus !== 8'h5A) begin
            n_err++;
            $display("FAIL cpu_rw_both_strobes_bus: bus=%h, required 5a", ram_bus);
        end
        cycle();
        idle();
        ref_mem[7] = 8'h5A;
        repeat (6) begin
            a = $urandom_range(0, DEPTH - 1);
            v = DW'($urandom_range(0, 254));
            cpu_write(a, v);
            ref_mem[a] = v;
        end
        for (int k = 0; k < DEPTH; k++) begin
            read_word(k, d);
            n_vec++;
            if (d !== ref_mem[k]) begin
                n_err++;
                $display("FAIL cpu_rw_sweep: addr %0d read %h, required %h", k, d, ref_mem[k]);
            end
        end
    endtask

    task automatic test_full_load();
        logic [DW-1:0] d;
        cycle();
        io.prog_start = 1'b1;
        cycle();
        io.prog_start = 1'b0;
        n_vec++;
        if (io.prog_ready !== 1'b1 || io.ram_rdy !== 1'b0 || io.prog_cnt !== '0) begin
            n_err++;
            $display("FAIL full_load_enter: ready=%b rdy=%b cnt=%0d, required 1/0/0",
                     io.prog_ready, io.ram_rdy, io.prog_cnt);
        end
        for (int k = 0; k < DEPTH; k++) begin
            io.prog_valid = 1'b1;
            io.prog_data  = DW'(8'h10 + k);
            io.prog_last  = 1'b0;
            cycle();
            ref_mem[k] = DW'(8'h10 + k);
            n_vec++;
            if (io.prog_ready !== (k < DEPTH - 1)) begin
                n_err++;
                $display("FAIL full_load_ready: word %0d ready=%b, required %b",
                         k, io.prog_ready, (k < DEPTH - 1));
            end
        end
        idle();
        n_vec++;
        if (io.ram_rdy !== 1'b1 || io.prog_cnt !== (AW + 1)'(DEPTH)) begin
            n_err++;
            $display("FAIL full_load_exit: rdy=%b cnt=%0d, required 1/%0d",
                     io.ram_rdy, io.prog_cnt, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            read_word(k, d);
            n_vec++;
            if (d !== ref_mem[k]) begin
                n_err++;
                $display("FAIL full_load_sweep: addr %0d read %h, required %h", k, d, ref_mem[k]);
            end
        end
    endtask

    task automatic test_short_load();
        logic [DW-1:0] d;
        logic [DW-1:0] words [3];
        words[0] = 8'h1F;
        words[1] = 8'h2F;
        words[2] = 8'h79;
        cpu_write(3, 8'h3C);
        ref_mem[3] = 8'h3C;
        cycle();
        io.prog_start = 1'b1;
        cycle();
        io.prog_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            io.prog_valid = 1'b0;
            io.ram_add    = AW'(3);
            io.ram_out    = 1'b1;
            #2;
            n_vec++;
            if (ram_bus !== FLOAT) begin
                n_err++;
                $display("FAIL load_read_ignored: bus=%h, required %h", ram_bus, FLOAT);
            end
            cycle();
            io.ram_out    = 1'b0;
            io.ram_add    = AW'(5);
            io.ram_in     = 1'b1;
            tb_drv        = 1'b1;
            tb_wdata      = 8'hEE;
            io.prog_start = 1'b1;
            cycle();
            io.ram_in     = 1'b0;
            tb_drv        = 1'b0;
            io.prog_start = 1'b0;
            io.prog_valid = 1'b1;
            io.prog_data  = words[i];
            io.prog_last  = (i == 2);
            cycle();
            ref_mem[i] = words[i];
            n_vec++;
            if (io.prog_cnt !== (AW + 1)'(i + 1) || io.prog_ready !== (i < 2)) begin
                n_err++;
                $display("FAIL short_load_step: word %0d cnt=%0d ready=%b, required %0d/%b",
                         i, io.prog_cnt, io.prog_ready, i + 1, (i < 2));
            end
        end
        idle();
        n_vec++;
        if (io.ram_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL short_load_exit: rdy=%b, required 1", io.ram_rdy);
        end
        for (int k = 0; k < DEPTH; k++) begin
            read_word(k, d);
            n_vec++;
            if (d !== ref_mem[k]) begin
                n_err++;
                $display("FAIL short_load_sweep: addr %0d read %h, required %h", k, d, ref_mem[k]);
            end
        end
        n_vec++;
        if (io.prog_cnt !== (AW + 1)'(3)) begin
            n_err++;
            $display("FAIL short_load_cnt_hold: cnt=%0d, required 3", io.prog_cnt);
        end
    endtask

    task automatic test_random_loads();
        logic [DW-1:0] d;
        logic [DW-1:0] v;
        int len;
        bit use_last;
        repeat (4) begin
            len      = $urandom_range(1, DEPTH);
            use_last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle();
            io.prog_start = 1'b1;
            cycle();
            io.prog_start = 1'b0;
            for (int i = 0; i < len; i++) begin
                io.prog_valid = 1'b0;
                repeat ($urandom_range(0, 2)) cycle();
                v = DW'($urandom_range(0, 254));
                io.prog_valid = 1'b1;
                io.prog_data  = v;
                io.prog_last  = (i == len - 1) && use_last;
                cycle();
                ref_mem[i] = v;
            end
            idle();
            n_vec++;
            if (io.prog_cnt !== (AW + 1)'(len) || io.ram_rdy !== 1'b1 || io.prog_ready !== 1'b0) begin
                n_err++;
                $display("FAIL random_load_exit: len %0d cnt=%0d rdy=%b ready=%b, required %0d/1/0",
                         len, io.prog_cnt, io.ram_rdy, io.prog_ready, len);
            end
            for (int k = 0; k < DEPTH; k++) begin
                read_word(k, d);
                n_vec++;
                if (d !== ref_mem[k]) begin
                    n_err++;
                    $display("FAIL random_load_sweep: addr %0d read %h, required %h",
                             k, d, ref_mem[k]);
                end
            end
        end
    endtask

    task automatic test_mid_load_reset();
        logic [DW-1:0] d;
        cycle();
        io.prog_start = 1'b1;
        cycle();
        io.prog_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            io.prog_valid = 1'b1;
            io.prog_data  = DW'($urandom_range(1, 254));
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        n_vec++;
        if (io.prog_ready !== 1'b0 || io.ram_rdy !== 1'b0 || io.prog_cnt !== '0) begin
            n_err++;
            $display("FAIL mid_reset_outputs: ready=%b rdy=%b cnt=%0d, required 0/0/0",
                     io.prog_ready, io.ram_rdy, io.prog_cnt);
        end
        rst = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            cycle();
            n_vec++;
            if (io.ram_rdy !== (k == DEPTH)) begin
                n_err++;
                $display("FAIL mid_reset_rdy_timing: edge %0d rdy=%b, required %b",
                         k, io.ram_rdy, (k == DEPTH));
            end
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
        for (int k = 0; k < DEPTH; k++) begin
            read_word(k, d);
            n_vec++;
            if (d !== ref_mem[k]) begin
                n_err++;
                $display("FAIL mid_reset_sweep: addr %0d read %h, required %h", k, d, ref_mem[k]);
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_cpu_rw();
        test_full_load();
        test_short_load();
        test_random_loads();
        test_mid_load_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
